// File: rtl/debounce_sched_pkg.sv
// Shared types and width helpers for the debounce scheduler and its event FIFO.
// Event words are packed as {dir, id}.
package debounce_sched_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } scan_state_t;

    // Event word: channel id in the low bits, direction in the top bit.
    function automatic int ev_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // Filter counter holds 0..cnt_max, so it needs clog2(cnt_max+1) bits.
    function automatic int cnt_width(input int cnt_max);
        return $clog2(cnt_max + 1);
    endfunction

endpackage

// File: rtl/debounce_sched_event_fifo.sv
// Small synchronous FIFO with an extra pointer bit for full/empty detection.
// The head word is presented combinationally so it is valid as soon as the entry lands.
module debounce_sched_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    assign dout = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/debounce_sched.sv
// Time-multiplexed debouncer: one prescaler tick triggers a scan that filters one
// channel per clock; every debounced edge is queued as an {dir, id} event.
module debounce_sched #(
    parameter int N     = 4,
    parameter int DIV   = 1000,
    parameter int CNT   = 3,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         sig_in,
    output logic [N-1:0]         sig_out,
    output logic                 ev_valid,
    output logic [$clog2(N)-1:0] ev_id,
    output logic                 ev_dir,
    input  logic                 ev_ready,
    output logic                 ovf
);
    import debounce_sched_pkg::*;

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(DIV);
    localparam int CW = cnt_width(CNT);
    localparam int EW = ev_width(N);

    logic [N-1:0]  sync_meta_reg;
    logic [N-1:0]  sync_reg;
    logic [PW-1:0] pcnt_reg;
    logic          tick;
    scan_state_t   state_reg;
    logic [IW-1:0] ch_reg;
    logic [N-1:0]  flip_vec;
    logic [N-1:0]  sig_out_vec;
    logic          push;
    logic [EW-1:0] push_word;
    logic [EW-1:0] head_word;
    logic          fifo_empty;
    logic          fifo_full;
    logic          ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_reg <= '0;
            sync_reg      <= '0;
        end else begin
            sync_meta_reg <= sig_in;
            sync_reg      <= sync_meta_reg;
        end
    end

    assign tick = (pcnt_reg == PW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_reg <= '0;
        end else if (tick) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_reg + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            ch_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    ch_reg <= '0;
                    if (tick) begin
                        state_reg <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (ch_reg == IW'(N - 1)) begin
                        state_reg <= S_IDLE;
                        ch_reg    <= '0;
                    end else begin
                        ch_reg <= ch_reg + IW'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    ch_reg    <= '0;
                end
            endcase
        end
    end

    // Each channel owns its filter counter and output level; only the scanned one updates.
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        logic [CW-1:0] cnt_reg;
        logic          out_reg;
        logic          sel;
        logic          differ;

        assign sel    = (state_reg == S_SCAN) && (ch_reg == IW'(gi));
        assign differ = sync_reg[gi] ^ out_reg;
        assign flip_vec[gi]    = sel && differ && (cnt_reg == CW'(CNT - 1));
        assign sig_out_vec[gi] = out_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
                out_reg <= 1'b0;
            end else if (sel) begin
                if (flip_vec[gi]) begin
                    cnt_reg <= '0;
                    out_reg <= ~out_reg;
                end else if (differ) begin
                    cnt_reg <= cnt_reg + CW'(1);
                end else begin
                    cnt_reg <= '0;
                end
            end
        end
    end

    // On a flip the new level equals the synchronized input of the scanned channel.
    assign push      = |flip_vec;
    assign push_word = {sync_reg[ch_reg], ch_reg};

    debounce_sched_event_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(EW)
    ) u_fifo (
        .clk  (clk),
        .srst (rst),
        .push (push),
        .din  (push_word),
        .pop  (ev_ready),
        .dout (head_word),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (push && fifo_full && !(ev_ready && !fifo_empty)) begin
            ovf_reg <= 1'b1;
        end
    end

    assign sig_out  = sig_out_vec;
    assign ev_valid = !fifo_empty;
    assign ev_id    = head_word[IW-1:0];
    assign ev_dir   = head_word[EW-1];
    assign ovf      = ovf_reg;

endmodule

// File: tb/tb_debounce_sched.sv
// Directed bench for debounce_sched with N=4, DIV=8, CNT=3, DEPTH=4.
// Window c is the interval just after the c-th clock edge following reset release.
module tb_debounce_sched;
    logic       clk;
    logic       rst;
    logic [3:0] sig_in;
    logic [3:0] sig_out;
    logic       ev_valid;
    logic [1:0] ev_id;
    logic       ev_dir;
    logic       ev_ready;
    logic       ovf;

    int cyc;
    int passed;
    int total;

    debounce_sched #(
        .N(4), .DIV(8), .CNT(3), .DEPTH(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sig_in  (sig_in),
        .sig_out (sig_out),
        .ev_valid(ev_valid),
        .ev_id   (ev_id),
        .ev_dir  (ev_dir),
        .ev_ready(ev_ready),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h (window %0d)", tag, obs, exp, cyc);
    endtask

    task automatic do_reset(input logic [3:0] after);
        rst      = 1'b1;
        ev_ready = 1'b0;
        sig_in   = 4'($urandom);
        step();
        step();
        step();
        rst    = 1'b0;
        sig_in = after;
        cyc    = 0;
    endtask

    task automatic check_head(input string tag, input logic [1:0] id, input logic dir);
        chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
        chk({tag, "_id"}, 32'(ev_id), 32'(id));
        chk({tag, "_dir"}, 32'(ev_dir), 32'(dir));
    endtask

    initial begin
        rst      = 1'b1;
        sig_in   = 4'd0;
        ev_ready = 1'b0;
        cyc      = 0;
        passed   = 0;
        total    = 0;

        // Reset with random inputs, then first tick at pcnt == 7.
        do_reset(4'b0000);
        chk("rst_sig_out", 32'(sig_out), 32'd0);
        chk("rst_ev_valid", 32'(ev_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_ev_id", 32'(ev_id), 32'd0);
        chk("rst_ev_dir", 32'(ev_dir), 32'd0);
        step_to(6);
        chk("no_tick_w6", 32'(dut.tick), 32'd0);
        step_to(7);
        chk("first_tick_w7", 32'(dut.tick), 32'd1);
        $display("reset: first tick window checked");

        // Clean rise on channel 2: ticks at 7,15,23, ch2 evaluated at 10,18,26.
        do_reset(4'b0100);
        step_to(26);
        chk("rise_before_sig_out", 32'(sig_out), 32'd0);
        chk("rise_before_valid", 32'(ev_valid), 32'd0);
        step_to(27);
        chk("rise_sig_out", 32'(sig_out), 32'b0100);
        check_head("rise_ev", 2'd2, 1'b1);
        step_to(30);
        check_head("rise_hold", 2'd2, 1'b1);
        chk("rise_ovf", 32'(ovf), 32'd0);
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        chk("rise_popped", 32'(ev_valid), 32'd0);
        $display("clean rise: ch2 event observed");

        // Glitch: ch0 high for two scans (8,16) then low before the third (24).
        do_reset(4'b0001);
        step_to(17);
        chk("glitch_cnt2", 32'(dut.g_ch[0].cnt_reg), 32'd2);
        sig_in = 4'b0000;
        step_to(25);
        chk("glitch_cnt_clear", 32'(dut.g_ch[0].cnt_reg), 32'd0);
        step_to(41);
        chk("glitch_sig_out", 32'(sig_out), 32'd0);
        chk("glitch_no_event", 32'(ev_valid), 32'd0);
        $display("glitch: rejected");

        // Overflow: four rises fill the FIFO, the ch0 fall at window 48 is dropped.
        do_reset(4'b1111);
        step_to(28);
        chk("ovf_all_high", 32'(sig_out), 32'b1111);
        check_head("ovf_head0", 2'd0, 1'b1);
        sig_in = 4'b1110;
        step_to(48);
        chk("ovf_before", 32'(ovf), 32'd0);
        step_to(49);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_sig_out", 32'(sig_out), 32'b1110);
        ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_head($sformatf("ovf_drain%0d", k), 2'(k), 1'b1);
            step();
        end
        chk("ovf_drained", 32'(ev_valid), 32'd0);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        ev_ready = 1'b0;
        $display("overflow: 4 events drained, fifth dropped");

        // Simultaneous push/pop while full at window 48.
        do_reset(4'b1111);
        step_to(28);
        sig_in = 4'b1110;
        step_to(48);
        check_head("pp_head0", 2'd0, 1'b1);
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        chk("pp_no_ovf", 32'(ovf), 32'd0);
        check_head("pp_head1", 2'd1, 1'b1);
        ev_ready = 1'b1;
        check_head("pp_d1", 2'd1, 1'b1);
        step();
        check_head("pp_d2", 2'd2, 1'b1);
        step();
        check_head("pp_d3", 2'd3, 1'b1);
        step();
        check_head("pp_fall0", 2'd0, 1'b0);
        step();
        chk("pp_empty", 32'(ev_valid), 32'd0);
        chk("pp_ovf_end", 32'(ovf), 32'd0);
        ev_ready = 1'b0;
        $display("push/pop while full: order kept, no drop");

        // Reset in the cycle ch1 would flip (third tick at 23, ch1 at 25).
        do_reset(4'b0010);
        step_to(10);
        chk("mid_cnt1", 32'(dut.g_ch[1].cnt_reg), 32'd1);
        step_to(25);
        chk("mid_cnt2", 32'(dut.g_ch[1].cnt_reg), 32'd2);
        chk("mid_pre_sig_out", 32'(sig_out), 32'd0);
        rst = 1'b1;
        step();
        chk("mid_rst_sig_out", 32'(sig_out), 32'd0);
        chk("mid_rst_valid", 32'(ev_valid), 32'd0);
        chk("mid_rst_cnt", 32'(dut.g_ch[1].cnt_reg), 32'd0);
        rst = 1'b0;
        cyc = 0;
        step_to(25);
        chk("mid_after_sig_out", 32'(sig_out), 32'd0);
        chk("mid_after_valid", 32'(ev_valid), 32'd0);
        step_to(26);
        chk("mid_flip_sig_out", 32'(sig_out), 32'b0010);
        check_head("mid_ev", 2'd1, 1'b1);
        $display("reset mid-scan: flip deferred by three new ticks");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
